// File: rtl/register_file.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Two combinational operand lookups with ROB-ready and same-cycle commit bypass.
module register_file #(
    parameter int ROB_SIZE_BIT = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_clear,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic [ROB_SIZE_BIT-1:0] issue_rob_idx,
    output logic [ROB_SIZE_BIT-1:0] rob_query1,
    output logic [ROB_SIZE_BIT-1:0] rob_query2,
    input  logic                    rob_ready1,
    input  logic                    rob_ready2,
    input  logic [31:0]             rob_value1,
    input  logic [31:0]             rob_value2,
    input  logic                    commit_valid,
    input  logic [4:0]              commit_rd,
    input  logic [ROB_SIZE_BIT-1:0] commit_rob_idx,
    input  logic [31:0]             commit_value,
    output logic [31:0]             val1,
    output logic [31:0]             val2,
    output logic [ROB_SIZE_BIT-1:0] dep1,
    output logic [ROB_SIZE_BIT-1:0] dep2,
    output logic                    has_dep1,
    output logic                    has_dep2
);

    logic [31:0]             regs_rd [32];
    logic                    busy_rd [32];
    logic [ROB_SIZE_BIT-1:0] tag_rd  [32];

    // x0 is a constant entry so the lookup needs no special case.
    assign regs_rd[0] = '0;
    assign busy_rd[0] = 1'b0;
    assign tag_rd[0]  = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [31:0]             value_reg;
            logic                    busy_reg;
            logic [ROB_SIZE_BIT-1:0] tag_reg;
            logic                    commit_hit;
            logic                    issue_hit;

            assign commit_hit = commit_valid && (commit_rd == 5'(gi));
            assign issue_hit  = issue_valid && (issue_rd == 5'(gi));

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    value_reg <= '0;
                    busy_reg  <= 1'b0;
                    tag_reg   <= '0;
                end else if (rdy_in) begin
                    if (commit_hit)
                        value_reg <= commit_value;
                    // A fresh rename outranks a commit that would clear busy.
                    if (rob_clear) begin
                        busy_reg <= 1'b0;
                    end else if (issue_hit) begin
                        busy_reg <= 1'b1;
                        tag_reg  <= issue_rob_idx;
                    end else if (commit_hit && busy_reg && (tag_reg == commit_rob_idx)) begin
                        busy_reg <= 1'b0;
                    end
                end
            end

            assign regs_rd[gi] = value_reg;
            assign busy_rd[gi] = busy_reg;
            assign tag_rd[gi]  = tag_reg;
        end
    endgenerate

    logic [4:0]              src       [2];
    logic                    ready_arr [2];
    logic [31:0]             rob_v_arr [2];
    logic [31:0]             val_arr   [2];
    logic [ROB_SIZE_BIT-1:0] dep_arr   [2];
    logic [ROB_SIZE_BIT-1:0] query_arr [2];
    logic                    hd_arr    [2];

    assign src[0]       = rs1;
    assign src[1]       = rs2;
    assign ready_arr[0] = rob_ready1;
    assign ready_arr[1] = rob_ready2;
    assign rob_v_arr[0] = rob_value1;
    assign rob_v_arr[1] = rob_value2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_lookup
            always_comb begin
                query_arr[gi] = tag_rd[src[gi]];
                val_arr[gi]   = '0;
                dep_arr[gi]   = '0;
                hd_arr[gi]    = 1'b0;
                if (!busy_rd[src[gi]]) begin
                    val_arr[gi] = regs_rd[src[gi]];
                end else if (ready_arr[gi]) begin
                    val_arr[gi] = rob_v_arr[gi];
                    dep_arr[gi] = tag_rd[src[gi]];
                end else if (commit_valid && (commit_rob_idx == tag_rd[src[gi]])) begin
                    val_arr[gi] = commit_value;
                    dep_arr[gi] = tag_rd[src[gi]];
                end else begin
                    dep_arr[gi] = tag_rd[src[gi]];
                    hd_arr[gi]  = 1'b1;
                end
            end
        end
    endgenerate

    assign rob_query1 = query_arr[0];
    assign rob_query2 = query_arr[1];
    assign val1       = val_arr[0];
    assign val2       = val_arr[1];
    assign dep1       = dep_arr[0];
    assign dep2       = dep_arr[1];
    assign has_dep1   = hd_arr[0];
    assign has_dep2   = hd_arr[1];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a behavioural model predicts each lookup,
// predictions are queued when stimulus is driven and compared at the falling edge.
module tb_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic [4:0]  rs1, rs2;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_idx;
    logic [3:0]  rob_query1, rob_query2;
    logic        rob_ready1, rob_ready2;
    logic [31:0] rob_value1, rob_value2;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_rob_idx;
    logic [31:0] commit_value;
    logic [31:0] val1, val2;
    logic [3:0]  dep1, dep2;
    logic        has_dep1, has_dep2;

    register_file #(.ROB_SIZE_BIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .rs1(rs1), .rs2(rs2),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_idx(issue_rob_idx),
        .rob_query1(rob_query1), .rob_query2(rob_query2),
        .rob_ready1(rob_ready1), .rob_ready2(rob_ready2),
        .rob_value1(rob_value1), .rob_value2(rob_value2),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_rob_idx(commit_rob_idx), .commit_value(commit_value),
        .val1(val1), .val2(val2), .dep1(dep1), .dep2(dep2),
        .has_dep1(has_dep1), .has_dep2(has_dep2)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] val;
        logic [3:0]  dep;
        logic        hd;
        logic [3:0]  query;
    } op_t;

    typedef struct packed {
        op_t a;
        op_t b;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [3:0]  m_tag  [32];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          txn          = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s txn=%0d got=%h expected=%h", tag, txn, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    function automatic op_t model_lookup(input logic [4:0] s, input logic rdy, input logic [31:0] rv);
        op_t o;
        o = '0;
        if (s == 5'd0) return o;
        o.query = m_tag[s];
        if (!m_busy[s]) begin
            o.val = m_regs[s];
        end else begin
            o.dep = m_tag[s];
            if (rdy)
                o.val = rv;
            else if (commit_valid && commit_rob_idx == m_tag[s])
                o.val = commit_value;
            else
                o.hd = 1'b1;
        end
        return o;
    endfunction

    task automatic model_edge();
        if (rst_in) begin
            model_reset();
        end else if (rdy_in) begin
            if (commit_valid && commit_rd != 5'd0)
                m_regs[commit_rd] = commit_value;
            if (rob_clear) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (commit_valid && commit_rd != 5'd0 && m_busy[commit_rd] &&
                    m_tag[commit_rd] == commit_rob_idx)
                    m_busy[commit_rd] = 1'b0;
                if (issue_valid && issue_rd != 5'd0) begin
                    m_busy[issue_rd] = 1'b1;
                    m_tag[issue_rd]  = issue_rob_idx;
                end
            end
        end
    endtask

    task automatic idle();
        rdy_in = 1'b1; rob_clear = 1'b0; rs1 = '0; rs2 = '0;
        issue_valid = 1'b0; issue_rd = '0; issue_rob_idx = '0;
        rob_ready1 = 1'b0; rob_ready2 = 1'b0; rob_value1 = '0; rob_value2 = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_rob_idx = '0; commit_value = '0;
    endtask

    // Entered just after a rising edge with inputs already driven.
    task automatic cycle();
        exp_t e;
        exp_t got;
        if (rst_in) model_reset();
        e.a = model_lookup(rs1, rob_ready1, rob_value1);
        e.b = model_lookup(rs2, rob_ready2, rob_value2);
        sb_q.push_back(e);
        @(negedge clk_in);
        got = sb_q.pop_front();
        check_eq("val1",   val1,              got.a.val);
        check_eq("dep1",   32'(dep1),         32'(got.a.dep));
        check_eq("hdep1",  32'(has_dep1),     32'(got.a.hd));
        check_eq("query1", 32'(rob_query1),   32'(got.a.query));
        check_eq("val2",   val2,              got.b.val);
        check_eq("dep2",   32'(dep2),         32'(got.b.dep));
        check_eq("hdep2",  32'(has_dep2),     32'(got.b.hd));
        check_eq("query2", 32'(rob_query2),   32'(got.b.query));
        $display("[TB] txn %0d rs1=%0d rs2=%0d val1=%h dep1=%0d hd1=%b val2=%h dep2=%0d hd2=%b",
                 txn, rs1, rs2, val1, dep1, has_dep1, val2, dep2, has_dep2);
        txn++;
        @(posedge clk_in);
        model_edge();
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst_in = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Reset state.
        rs1 = 5'd5; rs2 = 5'd0; cycle();

        // Rename then lookup via ROB.
        issue_valid = 1; issue_rd = 5; issue_rob_idx = 3; cycle();
        rs1 = 5; cycle();
        rs1 = 5; rob_ready1 = 1; rob_value1 = 32'h1234; cycle();

        // Rename conflict with commit of the same register.
        rs1 = 5; commit_valid = 1; commit_rd = 5; commit_rob_idx = 3; commit_value = 32'hAB;
        issue_valid = 1; issue_rd = 5; issue_rob_idx = 7; cycle();
        rs1 = 5; cycle();
        commit_valid = 1; commit_rd = 5; commit_rob_idx = 7; commit_value = 32'h55; cycle();
        rs1 = 5; cycle();

        // Stale commit.
        issue_valid = 1; issue_rd = 6; issue_rob_idx = 1; cycle();
        issue_valid = 1; issue_rd = 6; issue_rob_idx = 2; cycle();
        rs2 = 6; commit_valid = 1; commit_rd = 6; commit_rob_idx = 1; commit_value = 9; cycle();
        rs2 = 6; cycle();
        rs2 = 6; commit_valid = 1; commit_rd = 6; commit_rob_idx = 2; commit_value = 4; cycle();
        rs2 = 6; cycle();

        // Same-cycle bypass and x0.
        issue_valid = 1; issue_rd = 7; issue_rob_idx = 4; cycle();
        rs1 = 7; commit_valid = 1; commit_rd = 7; commit_rob_idx = 4; commit_value = 32'h77; cycle();
        issue_valid = 1; issue_rd = 0; issue_rob_idx = 5;
        commit_valid = 1; commit_rd = 0; commit_rob_idx = 9; commit_value = 5; cycle();
        rs1 = 0; rs2 = 0; cycle();

        // Flush and stall.
        for (int r = 1; r <= 3; r++) begin
            commit_valid = 1; commit_rd = 5'(r); commit_rob_idx = 4'(10 + r);
            commit_value = 32'h11 * r; cycle();
        end
        for (int r = 1; r <= 3; r++) begin
            issue_valid = 1; issue_rd = 5'(r); issue_rob_idx = 4'(r); cycle();
        end
        rdy_in = 0; rob_clear = 1; commit_valid = 1; commit_rd = 2; commit_value = 32'hDEAD;
        issue_valid = 1; issue_rd = 4; issue_rob_idx = 6; cycle();
        rs1 = 1; rs2 = 2; cycle();
        rs1 = 3; rs2 = 4; cycle();
        rob_clear = 1; commit_valid = 1; commit_rd = 2; commit_rob_idx = 15; commit_value = 32'h22;
        issue_valid = 1; issue_rd = 4; issue_rob_idx = 6; cycle();
        rs1 = 1; rs2 = 2; cycle();
        rs1 = 3; rs2 = 4; cycle();

        // Randomised traffic over a narrow register/tag range to force collisions.
        for (int n = 0; n < 300; n++) begin
            rdy_in         = ($urandom_range(0, 7) != 0);
            rob_clear      = ($urandom_range(0, 24) == 0);
            rs1            = 5'($urandom_range(0, 7));
            rs2            = 5'($urandom_range(0, 7));
            issue_valid    = 1'($urandom_range(0, 1));
            issue_rd       = 5'($urandom_range(0, 7));
            issue_rob_idx  = 4'($urandom_range(0, 5));
            rob_ready1     = ($urandom_range(0, 3) == 0);
            rob_ready2     = ($urandom_range(0, 3) == 0);
            rob_value1     = $urandom;
            rob_value2     = $urandom;
            commit_valid   = 1'($urandom_range(0, 1));
            commit_rd      = 5'($urandom_range(0, 7));
            commit_rob_idx = 4'($urandom_range(0, 5));
            commit_value   = $urandom;
            cycle();
        end

        // Asynchronous reset mid-operation.
        for (int r = 1; r <= 3; r++) begin
            issue_valid = 1; issue_rd = 5'(r + 8); issue_rob_idx = 4'(r); cycle();
        end
        rs1 = 9; rs2 = 10;
        #2 rst_in = 1'b1;
        cycle();
        rst_in = 1'b0;
        rs1 = 11; rs2 = 9; cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
